// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding and hazard controller for one VLIW issue slot.
// Tracks own and partner destinations through EX and MEM, registers mux selects, stalls ID.
module fwd_hazard_ctrl #(
  parameter int RAW   = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [RAW-1:0]   id_rs,
  input  logic [RAW-1:0]   id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_use_imm,
  input  logic [RAW-1:0]   id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic [RAW-1:0]   oth_rd,
  input  logic             oth_we,
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_IMM = 2'b11;

  logic [RAW-1:0]   ex_rd_q, ex_rd_d, ex_ord_q, ex_ord_d;
  logic             ex_we_q, ex_we_d, ex_ld_q, ex_ld_d, ex_owe_q, ex_owe_d;
  logic [RAW-1:0]   mem_rd_q, mem_rd_d, mem_ord_q, mem_ord_d;
  logic             mem_we_q, mem_we_d, mem_owe_q, mem_owe_d;
  logic [1:0]       sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic a_used, b_used;
  logic a_ex, a_mem, a_oex, a_omem;
  logic b_ex, b_mem, b_oex, b_omem;
  logic hazard, stall_w, issue, adv;

  function automatic logic hit(input logic used, input logic we,
                               input logic [RAW-1:0] rd, input logic [RAW-1:0] src);
    return used && we && (rd != '0) && (rd == src);
  endfunction

  always_comb begin
    a_used = id_rs_used;
    b_used = id_rt_used && !id_use_imm;

    a_ex   = hit(a_used, ex_we_q,   ex_rd_q,   id_rs);
    a_mem  = hit(a_used, mem_we_q,  mem_rd_q,  id_rs);
    a_oex  = hit(a_used, ex_owe_q,  ex_ord_q,  id_rs);
    a_omem = hit(a_used, mem_owe_q, mem_ord_q, id_rs);
    b_ex   = hit(b_used, ex_we_q,   ex_rd_q,   id_rt);
    b_mem  = hit(b_used, mem_we_q,  mem_rd_q,  id_rt);
    b_oex  = hit(b_used, ex_owe_q,  ex_ord_q,  id_rt);
    b_omem = hit(b_used, mem_owe_q, mem_ord_q, id_rt);

    // No cross-slot bypass exists, and a load in EX has no result yet.
    hazard  = a_oex || a_omem || b_oex || b_omem || (ex_ld_q && (a_ex || b_ex));
    stall_w = id_valid && !flush && !reset && hazard;
    adv     = !flush && !stall_w;
    issue   = id_valid && adv;
  end

  always_comb begin
    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    if (issue) begin
      if (a_ex)       sel_a_d = SEL_EX;
      else if (a_mem) sel_a_d = SEL_MEM;

      if (id_use_imm) sel_b_d = SEL_IMM;
      else if (b_ex)  sel_b_d = SEL_EX;
      else if (b_mem) sel_b_d = SEL_MEM;
    end

    ex_rd_d  = id_rd;
    ex_we_d  = issue && id_we;
    ex_ld_d  = issue && id_is_load;
    // Partner bundle advances whenever the bundle is not held or killed.
    ex_ord_d = oth_rd;
    ex_owe_d = adv && oth_we;

    mem_rd_d  = ex_rd_q;
    mem_we_d  = ex_we_q && !flush;
    mem_ord_d = ex_ord_q;
    mem_owe_d = ex_owe_q && !flush;

    cnt_d = cnt_q;
    if (stall_w && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rd_q   <= '0;
      ex_we_q   <= 1'b0;
      ex_ld_q   <= 1'b0;
      ex_ord_q  <= '0;
      ex_owe_q  <= 1'b0;
      mem_rd_q  <= '0;
      mem_we_q  <= 1'b0;
      mem_ord_q <= '0;
      mem_owe_q <= 1'b0;
      sel_a_q   <= SEL_RF;
      sel_b_q   <= SEL_RF;
      cnt_q     <= '0;
    end else begin
      ex_rd_q   <= ex_rd_d;
      ex_we_q   <= ex_we_d;
      ex_ld_q   <= ex_ld_d;
      ex_ord_q  <= ex_ord_d;
      ex_owe_q  <= ex_owe_d;
      mem_rd_q  <= mem_rd_d;
      mem_we_q  <= mem_we_d;
      mem_ord_q <= mem_ord_d;
      mem_owe_q <= mem_owe_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sel_a     = sel_a_q;
  assign sel_b     = sel_b_q;
  assign stall     = stall_w;
  assign stall_cnt = cnt_q;

endmodule
